ysyx_24090012_regfile_sb: RTL and testbench

- Parametrised successor of the core's integer register file.
- Configurable register count (RV32E/RV32I), NUM_RD read ports, valid/ready write-back channel, optional legacy one-cycle write bubble.
- Per-register pending-write scoreboard with allocate/retire counters, so the IDU can detect RAW hazards against multiple outstanding EXU/LSU writes.
- Sits between IDU (reads, allocate) and WBU (write-back).

---
 rtl/ysyx_24090012_rf_pkg.sv | 21 ++
 rtl/ysyx_24090012_sb_counter.sv | 41 ++++
 rtl/ysyx_24090012_regfile_sb.sv | 153 +++++++++++++++
 tb/tb_ysyx_24090012_regfile_sb.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24090012_rf_pkg.sv
// Shared definitions for the scoreboarded register file: register counts,
// the address type, the write-back bubble state and the address validity rule.
package ysyx_24090012_rf_pkg;

    localparam int RV32E_NUM_REGS = 16;
    localparam int RV32I_NUM_REGS = 32;
    localparam int REG_ADDR_W     = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic {
        WB_ST_OPEN   = 1'b0,
        WB_ST_BUBBLE = 1'b1
    } wb_state_e;

    // x0 is hardwired to zero and anything at or beyond num_regs does not exist.
    function automatic logic is_valid_reg(input logic [31:0] addr, input int unsigned num_regs);
        return (addr != 32'd0) && (addr < num_regs);
    endfunction

endpackage

// File: rtl/ysyx_24090012_sb_counter.sv
// Saturating up/down pending-write counter for one architectural register.
module ysyx_24090012_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             full
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Simultaneous inc and dec cancel; dec at zero is a write-back with no reservation.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign full = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ysyx_24090012_regfile_sb.sv
// Integer register file with per-register pending-write scoreboard and a valid/ready write-back port.
// Same-cycle write-back forwarding to the read ports is enabled by defining YSYX_24090012_RF_BYPASS_EN.
module ysyx_24090012_regfile_sb
    import ysyx_24090012_rf_pkg::*;
#(
    parameter int NUM_REGS   = RV32I_NUM_REGS,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int CNT_W      = 2,
    parameter int WB_BUBBLE  = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         alloc_valid,
    input  logic [ADDR_WIDTH-1:0]        alloc_addr,
    output logic                         alloc_ready,
    input  logic                         wb_valid,
    input  logic [ADDR_WIDTH-1:0]        wb_addr,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    output logic                         wb_ready,
    input  logic                         flush,
    input  logic [ADDR_WIDTH-1:0]        dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_data
);

    logic wb_fire;
    logic alloc_fire;
    logic wb_addr_ok;
    logic alloc_addr_ok;

    logic [NUM_REGS-1:1] wr_hit;
    logic [NUM_REGS-1:1] alloc_hit;
    logic [NUM_REGS-1:1] cnt_full;
    logic [CNT_W-1:0]    cnt_val [NUM_REGS-1:1];

    logic [DATA_WIDTH-1:0] rf_d [NUM_REGS-1:1];
    logic [DATA_WIDTH-1:0] rf_q [NUM_REGS-1:1];

    wb_state_e wb_state_d, wb_state_q;

    assign wb_ready      = (wb_state_q == WB_ST_OPEN);
    assign wb_fire       = wb_valid & wb_ready;
    assign wb_addr_ok    = is_valid_reg(32'(wb_addr), NUM_REGS);
    assign alloc_addr_ok = is_valid_reg(32'(alloc_addr), NUM_REGS);

    // Only a reservation that would overflow a full counter is refused.
    always_comb begin
        alloc_ready = 1'b1;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (alloc_addr_ok && (alloc_addr == ADDR_WIDTH'(r)) && cnt_full[r]) begin
                alloc_ready = 1'b0;
            end
        end
    end

    assign alloc_fire = alloc_valid & alloc_ready & ~flush;

    always_comb begin
        wr_hit    = '0;
        alloc_hit = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            wr_hit[r]    = wb_fire && wb_addr_ok && (wb_addr == ADDR_WIDTH'(r));
            alloc_hit[r] = alloc_fire && alloc_addr_ok && (alloc_addr == ADDR_WIDTH'(r));
        end
    end

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        ysyx_24090012_sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (alloc_hit[g]),
            .dec   (wr_hit[g]),
            .clr   (flush),
            .cnt   (cnt_val[g]),
            .full  (cnt_full[g])
        );
    end

    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            rf_d[r] = rf_q[r];
            if (wr_hit[r]) begin
                rf_d[r] = wb_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                rf_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                rf_q[r] <= rf_d[r];
            end
        end
    end

    // An accepted write closes the port for exactly one cycle when the bubble is enabled.
    always_comb begin
        wb_state_d = WB_ST_OPEN;
        if ((WB_BUBBLE != 0) && wb_fire) begin
            wb_state_d = WB_ST_BUBBLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_state_q <= WB_ST_OPEN;
        end else begin
            wb_state_q <= wb_state_d;
        end
    end

    // Invalid addresses never match a loop index, so they fall through to zero / not busy.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (raddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] = rf_q[r];
                    rbusy[i] = (cnt_val[r] != '0);
`ifdef YSYX_24090012_RF_BYPASS_EN
                    if (wr_hit[r]) begin
                        rdata[i*DATA_WIDTH +: DATA_WIDTH] = wb_data;
                    end
                    if ((cnt_val[r] == CNT_W'(1)) && wr_hit[r] && !alloc_hit[r]) begin
                        rbusy[i] = 1'b0;
                    end
`endif
                end
            end
        end
    end

    always_comb begin
        dbg_data = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (dbg_addr == ADDR_WIDTH'(r)) begin
                dbg_data = rf_q[r];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24090012_regfile_sb.sv
// Bench for the scoreboarded register file: directed literal checks plus a random
// run compared every cycle against a behavioural model of the register file.
module tb_ysyx_24090012_regfile_sb;

    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NRD = 2;
    localparam int CW  = 2;

    logic clock = 1'b0;
    logic reset;

    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rbusy;
    logic              alloc_valid;
    logic [AW-1:0]     alloc_addr;
    logic              alloc_ready;
    logic              wb_valid;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              wb_ready;
    logic              flush;
    logic [AW-1:0]     dbg_addr;
    logic [DW-1:0]     dbg_data;

    logic [NRD*AW-1:0] s_raddr;
    logic [NRD*DW-1:0] s_rdata;
    logic [NRD-1:0]    s_rbusy;
    logic              s_alloc_valid;
    logic [AW-1:0]     s_alloc_addr;
    logic              s_alloc_ready;
    logic              s_wb_valid;
    logic [AW-1:0]     s_wb_addr;
    logic [DW-1:0]     s_wb_data;
    logic              s_wb_ready;
    logic [DW-1:0]     s_dbg_data;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    ysyx_24090012_regfile_sb #(
        .NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NRD), .CNT_W(CW), .WB_BUBBLE(1)
    ) u_dut (
        .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .flush(flush), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    ysyx_24090012_regfile_sb #(
        .NUM_REGS(16), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NRD), .CNT_W(CW), .WB_BUBBLE(0)
    ) u_dut16 (
        .clock(clock), .reset(reset), .raddr(s_raddr), .rdata(s_rdata), .rbusy(s_rbusy),
        .alloc_valid(s_alloc_valid), .alloc_addr(s_alloc_addr), .alloc_ready(s_alloc_ready),
        .wb_valid(s_wb_valid), .wb_addr(s_wb_addr), .wb_data(s_wb_data), .wb_ready(s_wb_ready),
        .flush(1'b0), .dbg_addr(s_wb_addr), .dbg_data(s_dbg_data)
    );

    // Behavioural model of the 32-entry, bubbled instance.
    logic [DW-1:0] m_rf [NR];
    int            m_cnt [NR];
    bit            m_ready;

    function automatic bit m_valid(int a);
        return (a > 0) && (a < NR);
    endfunction

    function automatic bit m_wb_fire();
        return wb_valid && m_ready;
    endfunction

    function automatic bit m_alloc_ready();
        return !(m_valid(int'(alloc_addr)) && (m_cnt[int'(alloc_addr)] == (1 << CW) - 1));
    endfunction

    function automatic bit m_alloc_fire();
        return alloc_valid && m_alloc_ready() && !flush;
    endfunction

    function automatic logic [DW-1:0] m_rdata(int a);
        if (!m_valid(a)) return '0;
`ifdef YSYX_24090012_RF_BYPASS_EN
        if (m_wb_fire() && int'(wb_addr) == a) return wb_data;
`endif
        return m_rf[a];
    endfunction

    function automatic bit m_rbusy(int a);
        if (!m_valid(a)) return 1'b0;
`ifdef YSYX_24090012_RF_BYPASS_EN
        if (m_cnt[a] == 1 && m_wb_fire() && int'(wb_addr) == a
            && !(m_alloc_fire() && int'(alloc_addr) == a)) return 1'b0;
`endif
        return m_cnt[a] != 0;
    endfunction

    function automatic logic [DW-1:0] m_dbg(int a);
        return m_valid(a) ? m_rf[a] : '0;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_rf[i]  = '0;
                m_cnt[i] = 0;
            end
            m_ready = 1'b1;
        end else begin
            bit wf, af;
            int wa, aa;
            wf = m_wb_fire();
            af = m_alloc_fire();
            wa = int'(wb_addr);
            aa = int'(alloc_addr);
            if (wf && m_valid(wa)) m_rf[wa] = wb_data;
            if (flush) begin
                for (int i = 0; i < NR; i++) m_cnt[i] = 0;
            end else begin
                if (af && m_valid(aa) && !(wf && wa == aa)) m_cnt[aa] = m_cnt[aa] + 1;
                if (wf && m_valid(wa) && !(af && wa == aa) && m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
            end
            m_ready = !wf;
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare on every falling edge once the model has seen a reset.
    always @(negedge clock) begin
        if (chk_en) begin
            checkOutput("wb_ready", {31'd0, wb_ready}, {31'd0, m_ready});
            checkOutput("alloc_ready", {31'd0, alloc_ready}, {31'd0, m_alloc_ready()});
            checkOutput("dbg_data", dbg_data, m_dbg(int'(dbg_addr)));
            for (int i = 0; i < NRD; i++) begin
                checkOutput("rdata", rdata[i*DW +: DW], m_rdata(int'(raddr[i*AW +: AW])));
                checkOutput("rbusy", {31'd0, rbusy[i]}, {31'd0, m_rbusy(int'(raddr[i*AW +: AW]))});
            end
        end
    end

    // One cycle of main-DUT inputs, returning at the falling edge of that cycle.
    task automatic applyStimulus(input int ra0, input int ra1, input bit av, input int aa,
                                 input bit wv, input int wa, input logic [DW-1:0] wd, input bit fl);
        @(posedge clock);
        #1;
        raddr       = {AW'(ra1), AW'(ra0)};
        dbg_addr    = AW'(ra1);
        alloc_valid = av;
        alloc_addr  = AW'(aa);
        wb_valid    = wv;
        wb_addr     = AW'(wa);
        wb_data     = wd;
        flush       = fl;
        @(negedge clock);
    endtask

    function automatic int pick_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
    endfunction

    logic [3:0] ready_seen;
    int         fires;

    initial begin
        reset = 1'b1;
        raddr = '0; dbg_addr = '0; alloc_valid = 1'b0; alloc_addr = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
        s_raddr = '0; s_alloc_valid = 1'b0; s_alloc_addr = '0;
        s_wb_valid = 1'b0; s_wb_addr = '0; s_wb_data = '0;
        @(posedge clock);
        #1 chk_en = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        applyStimulus(0, 5, 1'b0, 31, 1'b0, 0, '0, 1'b0);
        checkOutput("rst_rdata0", rdata[0 +: DW], 32'h0);
        checkOutput("rst_rdata5", rdata[DW +: DW], 32'h0);
        checkOutput("rst_rbusy", {30'd0, rbusy}, 32'h0);
        checkOutput("rst_wb_ready", {31'd0, wb_ready}, 32'h1);
        checkOutput("rst_alloc_ready", {31'd0, alloc_ready}, 32'h1);
        applyStimulus(31, 31, 1'b0, 0, 1'b0, 0, '0, 1'b0);
        checkOutput("rst_rdata31", rdata[0 +: DW], 32'h0);

        // Held write to x5 under the bubble
        fires = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(5, 0, 1'b0, 0, 1'b1, 5, 32'hDEADBEEF, 1'b0);
            ready_seen[c] = wb_ready;
            if (wb_ready) fires++;
            if (c == 1) checkOutput("x5_after_fire", rdata[0 +: DW], 32'hDEADBEEF);
        end
        checkOutput("ready_pattern", {28'd0, ready_seen}, 32'h5);
        checkOutput("fire_count", fires, 2);
        applyStimulus(0, 5, 1'b0, 0, 1'b1, 0, 32'h1234, 1'b0);
        checkOutput("x0_wb_ready", {31'd0, wb_ready}, 32'h1);
        applyStimulus(0, 5, 1'b0, 0, 1'b0, 0, '0, 1'b0);
        checkOutput("x0_reads_zero", rdata[0 +: DW], 32'h0);
        checkOutput("x5_kept", rdata[DW +: DW], 32'hDEADBEEF);

        // 16-entry instance: out-of-range address 20 is accepted and ignored
        @(posedge clock);
        #1;
        s_wb_valid = 1'b1; s_wb_addr = 5'd20; s_wb_data = 32'hAA;
        s_alloc_valid = 1'b1; s_alloc_addr = 5'd20; s_raddr = {5'd15, 5'd20};
        @(negedge clock);
        checkOutput("r16_wb_ready", {31'd0, s_wb_ready}, 32'h1);
        checkOutput("r16_alloc_ready", {31'd0, s_alloc_ready}, 32'h1);
        @(posedge clock);
        #1;
        s_wb_addr = 5'd15; s_alloc_valid = 1'b0;
        @(negedge clock);
        checkOutput("r16_rdata20", s_rdata[0 +: DW], 32'h0);
        checkOutput("r16_rbusy20", {30'd0, s_rbusy}, 32'h0);
        checkOutput("r16_no_bubble", {31'd0, s_wb_ready}, 32'h1);
        @(posedge clock);
        #1;
        s_wb_valid = 1'b0; s_raddr = {5'd15, 5'd4};
        @(negedge clock);
        checkOutput("r16_rdata15", s_rdata[DW +: DW], 32'hAA);
        checkOutput("r16_rdata4", s_rdata[0 +: DW], 32'h0);

        // Saturating reservations on x3
        for (int c = 0; c < 3; c++) begin
            applyStimulus(3, 4, 1'b1, 3, 1'b0, 0, '0, 1'b0);
            checkOutput("x3_alloc_acc", {31'd0, alloc_ready}, 32'h1);
        end
        applyStimulus(3, 4, 1'b0, 3, 1'b0, 0, '0, 1'b0);
        checkOutput("x3_busy", {30'd0, rbusy}, 32'h1);
        checkOutput("x3_full", {31'd0, alloc_ready}, 32'h0);
        #1 alloc_addr = 5'd4;
        #1 checkOutput("x4_not_full", {31'd0, alloc_ready}, 32'h1);
        applyStimulus(3, 4, 1'b0, 3, 1'b1, 3, 32'h33, 1'b0);
        checkOutput("x3_wb_ready", {31'd0, wb_ready}, 32'h1);
        applyStimulus(3, 4, 1'b0, 3, 1'b0, 0, '0, 1'b0);
        checkOutput("x3_ready_again", {31'd0, alloc_ready}, 32'h1);
        checkOutput("x3_still_busy", {30'd0, rbusy}, 32'h1);
        for (int c = 0; c < 3; c++) applyStimulus(3, 4, 1'b0, 3, 1'b1, 3, 32'h33, 1'b0);
        applyStimulus(3, 4, 1'b0, 3, 1'b0, 0, '0, 1'b0);
        checkOutput("x3_idle", {30'd0, rbusy}, 32'h0);
        checkOutput("x3_data", rdata[0 +: DW], 32'h33);

        // Alloc and write-back to x7 together, then flush against an x8 alloc
        applyStimulus(7, 8, 1'b1, 7, 1'b0, 0, '0, 1'b0);
        applyStimulus(7, 8, 1'b1, 7, 1'b1, 7, 32'h77, 1'b0);
        checkOutput("x7_wb_ready", {31'd0, wb_ready}, 32'h1);
        applyStimulus(7, 8, 1'b1, 8, 1'b0, 0, '0, 1'b1);
        checkOutput("x7_busy_kept", {31'd0, rbusy[0]}, 32'h1);
        checkOutput("x7_data", rdata[0 +: DW], 32'h77);
        applyStimulus(7, 8, 1'b0, 8, 1'b0, 0, '0, 1'b0);
        checkOutput("flush_rbusy", {30'd0, rbusy}, 32'h0);

        // Write-back to a singly reserved x9 read on both ports
        applyStimulus(9, 9, 1'b1, 9, 1'b0, 0, '0, 1'b0);
        applyStimulus(9, 9, 1'b0, 9, 1'b1, 9, 32'h55, 1'b0);
        checkOutput("x9_wb_ready", {31'd0, wb_ready}, 32'h1);
`ifdef YSYX_24090012_RF_BYPASS_EN
        checkOutput("x9_rdata0", rdata[0 +: DW], 32'h55);
        checkOutput("x9_rdata1", rdata[DW +: DW], 32'h55);
        checkOutput("x9_rbusy", {30'd0, rbusy}, 32'h0);
`else
        checkOutput("x9_rdata0", rdata[0 +: DW], 32'h0);
        checkOutput("x9_rdata1", rdata[DW +: DW], 32'h0);
        checkOutput("x9_rbusy", {30'd0, rbusy}, 32'h3);
`endif
        applyStimulus(9, 9, 1'b0, 9, 1'b0, 0, '0, 1'b0);
        checkOutput("x9_after", rdata[0 +: DW], 32'h55);
        checkOutput("x9_free", {30'd0, rbusy}, 32'h0);

        // Random traffic, with a reset landing in the middle of it
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            reset       = (c >= 1500 && c < 1502);
            raddr       = {AW'(pick_addr()), AW'(pick_addr())};
            dbg_addr    = AW'(pick_addr());
            alloc_valid = $urandom_range(0, 1) == 1;
            alloc_addr  = AW'(pick_addr());
            wb_valid    = $urandom_range(0, 2) != 0;
            wb_addr     = AW'(pick_addr());
            wb_data     = $urandom;
            flush       = $urandom_range(0, 31) == 0;
        end
        @(posedge clock);
        #1;
        reset = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
        @(negedge clock);
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
